// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, mispredict redirect, memory wait + watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int PERF_W          = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [4:0]        i_id_rs1,
  input  logic [4:0]        i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_ex_valid,
  input  logic [4:0]        i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mispred,
  input  logic              i_mem_req,
  input  logic              i_mem_ready,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_stall_mem,
  output logic              o_flush_id,
  output logic              o_flush_ex,
  output logic              o_flush_mem,
  output logic              o_flush_wb,
  output logic              o_mem_fault,
  output logic [1:0]        o_state,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_REDIRECT = 2'b10
  } state_e;

  // With the watchdog disabled the wait counter only saturates, so any small width will do.
  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 8 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WD_LAST   = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [3:0]        RC_RELOAD = 4'((REDIRECT_CYCLES > 1) ? REDIRECT_CYCLES - 1 : 0);

  state_e            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [3:0]        r_rcnt, w_rcnt_nxt;
  logic              r_mem_fault, w_fault_set;

  logic w_wd_expire, w_mem_stall, w_mispred, w_redirect, w_load_use;
  logic w_rs1_hit, w_rs2_hit;
  logic w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic w_flush_id, w_flush_ex, w_flush_mem, w_flush_wb;

  assign w_wd_expire = (MEM_TIMEOUT != 0) && (r_state == ST_MEM_WAIT) &&
                       (r_wcnt == WD_LAST) && !i_mem_ready;
  assign w_mem_stall = i_mem_req & ~i_mem_ready & ~w_wd_expire;
  assign w_mispred   = i_ex_valid & i_ex_mispred;
  assign w_redirect  = w_mispred | (r_state == ST_REDIRECT);

  // x0 is hard-wired zero, so a load targeting it can never feed a dependent instruction.
  assign w_rs1_hit  = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign w_load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_stall_ex  = 1'b0;
    w_stall_mem = 1'b0;
    w_flush_id  = 1'b0;
    w_flush_ex  = 1'b0;
    w_flush_mem = 1'b0;
    w_flush_wb  = 1'b0;
    if (i_reset) begin
      if (w_wd_expire) begin
        w_flush_mem = 1'b1;
      end else if (w_mem_stall) begin
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_stall_ex  = 1'b1;
        w_stall_mem = 1'b1;
        w_flush_wb  = 1'b1;
      end else if (w_redirect) begin
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
      end else if (w_load_use) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_flush_ex = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_rcnt_nxt  = r_rcnt;
    w_fault_set = 1'b0;
    if (w_wd_expire) begin
      w_state_nxt = ST_IDLE;
      w_wcnt_nxt  = '0;
      w_fault_set = 1'b1;
    end else if (w_mem_stall) begin
      w_state_nxt = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) begin
        w_wcnt_nxt = WCNT_W'(1);
      end else if (r_wcnt != '1) begin
        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
      end
    end else begin
      w_wcnt_nxt = '0;
      if (w_mispred && (REDIRECT_CYCLES > 1)) begin
        w_state_nxt = ST_REDIRECT;
        w_rcnt_nxt  = RC_RELOAD;
      end else if ((r_state == ST_REDIRECT) && (r_rcnt > 4'd1)) begin
        w_rcnt_nxt = r_rcnt - 4'd1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_rcnt_nxt  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      if (w_fault_set) r_mem_fault <= 1'b1;
    end
  end

  assign o_stall_if  = w_stall_if;
  assign o_stall_id  = w_stall_id;
  assign o_stall_ex  = w_stall_ex;
  assign o_stall_mem = w_stall_mem;
  assign o_flush_id  = w_flush_id;
  assign o_flush_ex  = w_flush_ex;
  assign o_flush_mem = w_flush_mem;
  assign o_flush_wb  = w_flush_wb;
  assign o_mem_fault = r_mem_fault;
  assign o_state     = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic              w_any_stall, w_mispred_acc;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_any_stall   = w_stall_if | w_stall_id | w_stall_ex | w_stall_mem;
  assign w_mispred_acc = w_mispred & ~w_mem_stall & ~w_wd_expire;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_mispred_acc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REDIRECT_CYCLES=3, MEM_TIMEOUT=4).
// Each step queues the expected output vector; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int PERF_W = 32;

  logic              i_clk, i_reset;
  logic [4:0]        i_id_rs1, i_id_rs2, i_ex_rd;
  logic              i_id_use_rs1, i_id_use_rs2, i_ex_valid, i_ex_mem_read, i_ex_mispred;
  logic              i_mem_req, i_mem_ready;
  logic              o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic              o_flush_id, o_flush_ex, o_flush_mem, o_flush_wb, o_mem_fault;
  logic [1:0]        o_state;
  logic [PERF_W-1:0] o_stall_cnt, o_flush_cnt;

  pipe_hazard_ctrl #(
    .REDIRECT_CYCLES (3),
    .MEM_TIMEOUT     (4),
    .PERF_W          (PERF_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_valid    (i_ex_valid),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_mispred  (i_ex_mispred),
    .i_mem_req     (i_mem_req),
    .i_mem_ready   (i_mem_ready),
    .o_stall_if    (o_stall_if),
    .o_stall_id    (o_stall_id),
    .o_stall_ex    (o_stall_ex),
    .o_stall_mem   (o_stall_mem),
    .o_flush_id    (o_flush_id),
    .o_flush_ex    (o_flush_ex),
    .o_flush_mem   (o_flush_mem),
    .o_flush_wb    (o_flush_wb),
    .o_mem_fault   (o_mem_fault),
    .o_state       (o_state),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Vector: {stall_if,id,ex,mem, flush_id,ex,mem,wb, fault, state[1:0]}
  localparam logic [10:0] E_IDLE = 11'b0000_0000_0_00;
  localparam logic [10:0] E_LU   = 11'b1100_0100_0_00;
  localparam logic [10:0] E_MS0  = 11'b1111_0001_0_00;
  localparam logic [10:0] E_MSW  = 11'b1111_0001_0_01;
  localparam logic [10:0] E_RLS  = 11'b0000_0000_0_01;
  localparam logic [10:0] E_RD0  = 11'b0000_1100_0_00;
  localparam logic [10:0] E_RDR  = 11'b0000_1100_0_10;
  localparam logic [10:0] E_RDW  = 11'b0000_1100_0_01;
  localparam logic [10:0] E_WDX  = 11'b0000_0010_0_01;
  localparam logic [10:0] F      = 11'b0000_0000_1_00;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  exp_stall = 0;
  int  exp_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (sb_q.size() > 0) begin
      sb_t s;
      s = sb_q.pop_front();
      check(s.tag, 32'({o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
                        o_flush_id, o_flush_ex, o_flush_mem, o_flush_wb,
                        o_mem_fault, o_state}), 32'(s.v));
    end
  end

  task automatic clr();
    i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0;
    i_ex_valid = 1'b0; i_ex_rd = 5'd0; i_ex_mem_read = 1'b0; i_ex_mispred = 1'b0;
    i_mem_req = 1'b0; i_mem_ready = 1'b0;
  endtask

  task automatic set_ex(input logic valid, input logic load, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic use1,
                        input logic [4:0] rs2, input logic use2);
    i_ex_valid = valid; i_ex_mem_read = load; i_ex_rd = rd;
    i_id_rs1 = rs1; i_id_use_rs1 = use1; i_id_rs2 = rs2; i_id_use_rs2 = use2;
  endtask

  task automatic step(input string tag, input logic [10:0] e);
    sb_t s;
    s.tag = tag;
    s.v   = e;
    sb_q.push_back(s);
    if (|e[10:7]) exp_stall++;
    if (i_ex_valid && i_ex_mispred && e[6]) exp_flush++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_stall_cnt"}, o_stall_cnt, 32'(exp_stall));
    check({tag, "_flush_cnt"}, o_flush_cnt, 32'(exp_flush));
`else
    check({tag, "_stall_cnt"}, o_stall_cnt, 32'd0);
    check({tag, "_flush_cnt"}, o_flush_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b0;
    clr();
    set_ex(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    i_mem_req = 1'b1;
    @(posedge i_clk);
    #1;
    step("rst_outputs", E_IDLE);
    chk_perf("rst");
    i_reset = 1'b1;
    clr();
    step("idle", E_IDLE);

    // Load-use and its non-hazard variants
    set_ex(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);  step("lu_rs1", E_LU);
    clr();                                             step("lu_rs1_next", E_IDLE);
    set_ex(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1);  step("lu_rs2", E_LU);
    clr();                                             step("lu_rs2_next", E_IDLE);
    set_ex(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);  step("lu_x0", E_IDLE);
    set_ex(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd3, 1'b1);  step("lu_nouse", E_IDLE);
    set_ex(1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);  step("lu_alu", E_IDLE);
    set_ex(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);  step("lu_bubble", E_IDLE);
    clr();

    // Memory wait: 3 stalled cycles then release
    i_mem_req = 1'b1;
    step("ms_c1", E_MS0);
    step("ms_c2", E_MSW);
    step("ms_c3", E_MSW);
    i_mem_ready = 1'b1;
    step("ms_release", E_RLS);
    clr();
    step("ms_after", E_IDLE);

    // Single mispredict with three-cycle redirect window
    i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("mp_c1", E_RD0);
    clr();
    step("mp_c2", E_RDR);
    step("mp_c3", E_RDR);
    step("mp_done", E_IDLE);
    chk_perf("perf_mix");

    // Mispredict masked by memory stall, accepted on the release cycle
    i_mem_req = 1'b1; i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("mpms_stall", E_MS0);
    i_mem_ready = 1'b1;
    step("mpms_release", E_RDW);
    clr();
    step("mpms_r2", E_RDR);
    step("mpms_r3", E_RDR);
    step("mpms_done", E_IDLE);

    // Load-use ignored inside the redirect window, honoured afterwards
    i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("rdlu_mp", E_RD0);
    i_ex_mispred = 1'b0;
    set_ex(1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    step("rdlu_w2", E_RDR);
    step("rdlu_w3", E_RDR);
    step("rdlu_lu", E_LU);
    clr();

    // New mispredict on the last redirect cycle reloads the window
    i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("rl_mp1", E_RD0);
    clr();
    step("rl_w2", E_RDR);
    i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("rl_mp2", E_RDR);
    clr();
    step("rl_w4", E_RDR);
    step("rl_w5", E_RDR);
    step("rl_done", E_IDLE);
    chk_perf("perf_mp");

    // Watchdog expiry and sticky fault
    i_mem_req = 1'b1;
    step("wd_c1", E_MS0);
    step("wd_c2", E_MSW);
    step("wd_c3", E_MSW);
    step("wd_expire", E_WDX);
    clr();
    step("wd_fault", E_IDLE | F);
    step("wd_fault2", E_IDLE | F);
    i_mem_req = 1'b1;
    step("wd_fms1", E_MS0 | F);
    step("wd_fms2", E_MSW | F);

    // Reset asserted mid-MEM_WAIT
    do_reset();
    step("rst_memwait", E_IDLE);
    i_reset = 1'b1;
    clr();
    step("rst_mw_after", E_IDLE);
    chk_perf("perf_rst");

    // Reset asserted mid-REDIRECT
    i_ex_valid = 1'b1; i_ex_mispred = 1'b1;
    step("rr_mp", E_RD0);
    do_reset();
    step("rst_redirect", E_IDLE);
    i_reset = 1'b1;
    clr();
    step("rr_after", E_IDLE);

    @(negedge i_clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
